// File: rtl/flippy_bit_pkg.sv
// Shared types and constants for the Flippy Bit letter datapath.
package flippy_bit_pkg;

  localparam int NUM_SLOTS = 3;
  localparam int LETTER_W  = 8;
  localparam int YPOS_W    = 5;
  localparam int GRID_W    = 40;
  localparam int GRID_H    = 30;

  // x^8+x^6+x^5+x^4+1 expressed as the feedback bits of a left-shifting register
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef struct packed {
    logic                active;
    logic [LETTER_W-1:0] letter;
    logic [YPOS_W-1:0]   ypos;
  } slot_t;

  function automatic logic [NUM_SLOTS-1:0] lowest_set(input logic [NUM_SLOTS-1:0] req);
    logic [NUM_SLOTS-1:0] oh;
    oh = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (req[i]) oh = NUM_SLOTS'(1) << i;
    end
    return oh;
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR used as the letter generator; holds when advance is low.
module lfsr8
  import flippy_bit_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       advance,
  output logic [7:0] value
);

  logic [7:0] value_q;
  logic [7:0] value_d;

  always_comb begin
    value_d = value_q;
    if (advance) value_d = {value_q[6:0], ^(value_q & LFSR_TAPS)};
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) value_q <= SEED;
    else       value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/letter_manager.sv
// Spawns, advances and retires the falling letters, and checks submitted guesses.
module letter_manager
  import flippy_bit_pkg::*;
#(
  parameter int         FLOOR_Y   = 29,
  parameter int         SPAWN_GAP = 8,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                enable,
  input  logic                step,
  input  logic                submit,
  input  logic [LETTER_W-1:0] guess,
  output logic [LETTER_W-1:0] letter1,
  output logic [LETTER_W-1:0] letter2,
  output logic [LETTER_W-1:0] letter3,
  output logic [YPOS_W-1:0]   ypos1,
  output logic [YPOS_W-1:0]   ypos2,
  output logic [YPOS_W-1:0]   ypos3,
  output logic [NUM_SLOTS-1:0] active,
  output logic [NUM_SLOTS-1:0] correct,
  output logic [NUM_SLOTS-1:0] game_over
);

  localparam int CNT_W = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SPAWN_GAP - 1);
  localparam logic [YPOS_W-1:0] FLOOR    = YPOS_W'(FLOOR_Y);

  slot_t                slot_q [NUM_SLOTS];
  slot_t                slot_d [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] game_over_q, game_over_d;
  logic [NUM_SLOTS-1:0] correct_q, correct_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [LETTER_W-1:0]  lfsr_val;
  logic                 run;
  logic                 cnt_full;
  logic [NUM_SLOTS-1:0] act_vec, match_vec, clear_oh, spawn_oh, land_vec;

  assign run = enable & ~|game_over_q;

  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .advance  (run),
    .value    (lfsr_val)
  );

  // Both encoders look at start-of-cycle occupancy, so a slot cleared now cannot be refilled now.
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      act_vec[i]   = slot_q[i].active;
      match_vec[i] = slot_q[i].active && (slot_q[i].letter == guess);
    end
    cnt_full = (cnt_q == CNT_LAST);
    clear_oh = (run && submit) ? lowest_set(match_vec) : '0;
    spawn_oh = (run && step && cnt_full) ? lowest_set(~act_vec) : '0;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (run && step) begin
      if (!cnt_full)     cnt_d = cnt_q + 1'b1;
      else if (|spawn_oh) cnt_d = '0;
    end
    game_over_d = game_over_q | land_vec;
    correct_d   = clear_oh;
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    slot_t nxt;
    logic  land;

    always_comb begin
      nxt  = slot_q[g];
      land = 1'b0;
      if (clear_oh[g]) begin
        nxt = '0;
      end else if (spawn_oh[g]) begin
        nxt.active = 1'b1;
        nxt.letter = lfsr_val;
        nxt.ypos   = '0;
      end else if (run && step && slot_q[g].active) begin
        if (slot_q[g].ypos < FLOOR) nxt.ypos = slot_q[g].ypos + 1'b1;
        else                        land     = 1'b1;
      end
    end

    assign slot_d[g]   = nxt;
    assign land_vec[g] = land;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= '0;
      game_over_q <= '0;
      correct_q   <= '0;
      cnt_q       <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= slot_d[i];
      game_over_q <= game_over_d;
      correct_q   <= correct_d;
      cnt_q       <= cnt_d;
    end
  end

  assign letter1   = slot_q[0].letter;
  assign letter2   = slot_q[1].letter;
  assign letter3   = slot_q[2].letter;
  assign ypos1     = slot_q[0].ypos;
  assign ypos2     = slot_q[1].ypos;
  assign ypos3     = slot_q[2].ypos;
  assign active    = act_vec;
  assign correct   = correct_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_letter_manager.sv
// Directed bench for letter_manager: spawn cadence, fall, submit priority, halts and reset.
module tb_letter_manager;

  logic       clk = 1'b0;
  logic       rst, enable, step, submit;
  logic [7:0] guess;
  logic [7:0] letter1, letter2, letter3;
  logic [4:0] ypos1, ypos2, ypos3;
  logic [2:0] active, correct, game_over;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] lfsr_m, pre_m;
  bit         run_m;
  logic [7:0] l0, l1, ls, g_miss;

  letter_manager u_dut (
    .CLOCK_50  (clk),
    .reset     (rst),
    .enable    (enable),
    .step      (step),
    .submit    (submit),
    .guess     (guess),
    .letter1   (letter1),
    .letter2   (letter2),
    .letter3   (letter3),
    .ypos1     (ypos1),
    .ypos2     (ypos2),
    .ypos3     (ypos3),
    .active    (active),
    .correct   (correct),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs applied before the edge, outputs settle 1 ns after it.
  task automatic cyc(input logic st, input logic sb, input logic [7:0] g);
    step   = st;
    submit = sb;
    guess  = g;
    pre_m  = lfsr_m;
    @(posedge clk);
    if (run_m) lfsr_m = lfsr_next(lfsr_m);
    #1;
    step   = 1'b0;
    submit = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 8'h00);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_active"}, active, 3'b000);
    chk({tag, "_correct"}, correct, 3'b000);
    chk({tag, "_gameover"}, game_over, 3'b000);
    chk({tag, "_letters"}, {letter1, letter2, letter3}, 24'h0);
    chk({tag, "_ypos"}, {ypos1, ypos2, ypos3}, 15'h0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; step = 1'b0; submit = 1'b0; guess = 8'h00;
    run_m = 1'b0; lfsr_m = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    chk("reset_lfsr", u_dut.lfsr_val, 8'hA5);

    rst = 1'b0; enable = 1'b1; run_m = 1'b1;
    repeat (10) cyc(1'b0, 1'b0, 8'h00);
    chk_all_zero("idle");
    chk("idle_lfsr", u_dut.lfsr_val, lfsr_m);

    // First spawn on the 8th step, fall to the floor, land on the 30th step after spawn
    steps(7);
    chk("pre_spawn_active", active, 3'b000);
    cyc(1'b1, 1'b0, 8'h00);
    l0 = pre_m;
    chk("spawn_active", active, 3'b001);
    chk("spawn_ypos1", ypos1, 5'd0);
    chk("spawn_letter1", letter1, l0);
    steps(29);
    chk("floor_ypos1", ypos1, 5'd29);
    chk("floor_ypos23", {ypos2, ypos3}, {5'd21, 5'd13});
    chk("floor_active", active, 3'b111);
    chk("floor_no_go", game_over, 3'b000);
    cyc(1'b1, 1'b0, 8'h00);
    run_m = 1'b0;
    chk("land_gameover", game_over, 3'b001);
    chk("land_ypos1", ypos1, 5'd29);
    steps(5);
    cyc(1'b0, 1'b1, letter2);
    chk("halt_correct", correct, 3'b000);
    chk("halt_active", active, 3'b111);
    chk("halt_ypos", {ypos1, ypos2, ypos3}, {5'd29, 5'd22, 5'd14});
    chk("halt_gameover", game_over, 3'b001);
    chk("halt_lfsr", u_dut.lfsr_val, lfsr_m);

    // Mid-game reset takes effect without waiting for a clock edge
    rst = 1'b1;
    #2;
    chk_all_zero("midreset");
    chk("midreset_lfsr", u_dut.lfsr_val, 8'hA5);
    lfsr_m = 8'hA5;
    @(posedge clk);
    #1;
    rst = 1'b0; run_m = 1'b1;

    // Slot2 spawns exactly 255 cycles after slot0, so both carry the same letter
    steps(7);
    cyc(1'b1, 1'b0, 8'h00);
    l0 = pre_m;
    steps(7);
    cyc(1'b1, 1'b0, 8'h00);
    l1 = pre_m;
    steps(7);
    repeat (239) cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    chk("dup_letters", {letter1, letter2, letter3}, {l0, l1, l0});
    chk("dup_ypos", {ypos1, ypos2, ypos3}, {5'd16, 5'd8, 5'd0});
    chk("dup_active", active, 3'b111);
    steps(7);
    chk("full_ypos", {ypos1, ypos2, ypos3}, {5'd23, 5'd15, 5'd7});
    chk("full_active", active, 3'b111);

    g_miss = l0 + 8'd1;
    while (g_miss == l0 || g_miss == l1) g_miss = g_miss + 8'd1;
    cyc(1'b0, 1'b1, g_miss);
    chk("miss_correct", correct, 3'b000);
    chk("miss_active", active, 3'b111);
    chk("miss_ypos", {ypos1, ypos2, ypos3}, {5'd23, 5'd15, 5'd7});

    // Submit and step together at counter 7 with every slot full
    cyc(1'b1, 1'b1, l0);
    chk("sim_correct", correct, 3'b001);
    chk("sim_active", active, 3'b110);
    chk("sim_slot0", {letter1, ypos1}, 13'h0);
    chk("sim_ypos23", {ypos2, ypos3}, {5'd16, 5'd8});
    chk("sim_letter3", letter3, l0);
    cyc(1'b0, 1'b0, 8'h00);
    chk("sim_correct_drop", correct, 3'b000);
    chk("sim_no_spawn", active, 3'b110);
    cyc(1'b1, 1'b0, 8'h00);
    ls = pre_m;
    chk("respawn_active", active, 3'b111);
    chk("respawn_slot0", {letter1, ypos1}, {ls, 5'd0});
    chk("respawn_ypos23", {ypos2, ypos3}, {5'd17, 5'd9});

    // Enable low freezes everything, including the LFSR
    enable = 1'b0; run_m = 1'b0;
    repeat (20) cyc(1'b1, 1'b1, l1);
    chk("en_low_active", active, 3'b111);
    chk("en_low_correct", correct, 3'b000);
    chk("en_low_ypos", {ypos1, ypos2, ypos3}, {5'd0, 5'd17, 5'd9});
    chk("en_low_letter2", letter2, l1);
    chk("en_low_lfsr", u_dut.lfsr_val, lfsr_m);
    enable = 1'b1; run_m = 1'b1;
    cyc(1'b1, 1'b0, 8'h00);
    chk("resume_ypos", {ypos1, ypos2, ypos3}, {5'd1, 5'd18, 5'd10});

    // Back-to-back submits are each honoured
    cyc(1'b0, 1'b1, l1);
    chk("b2b_correct1", correct, 3'b010);
    cyc(1'b0, 1'b1, l0);
    chk("b2b_correct2", correct, 3'b100);
    chk("b2b_active", active, 3'b001);
    chk("end_lfsr", u_dut.lfsr_val, lfsr_m);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/letter_manager.md
# letter_manager

Spawns, drops and retires the three falling 8-bit letters of the Flippy Bit game. It sits between `Big_State_Machine` and `Display`. It feeds `Display` with `letter1..3` and `ypos1..3`, and feeds the state machine with per-slot `correct` pulses and `game_over` flags. It checks the player's switch value against live letters on each submit.

## Interface
Parameters:
- `FLOOR_Y`, default 29: last visible row; the 40x30 grid gives 1200 framebuffer bits.
- `SPAWN_GAP`, default 8: number of `step` pulses between spawns.
- `LFSR_SEED`, default 8'hA5: LFSR reset value; must be non-zero.

Ports:
- `CLOCK_50`  in  1  system clock; one clock, with all state on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  high while the game is running; when low, all state holds.
- `step`  in  1  one-cycle pulse per fall tick.
- `submit`  in  1  one-cycle pulse, already debounced.
- `guess`  in  8  switch value (`SW`).
- `letter1`, `letter2`, `letter3`  out  8  slot letters; 0 when the slot is inactive.
- `ypos1`, `ypos2`, `ypos3`  out  5  slot rows; 0 when the slot is inactive.
- `active`  out  3  slot-occupied mask.
- `correct`  out  3  one-cycle pulse on the cleared slot.
- `game_over`  out  3  sticky; set on the slot that hit the floor.

## Operation
- **Reset values:** letters 0, ypos 0, `active` 0, `correct` 0, `game_over` 0, LFSR = `LFSR_SEED`, spawn counter 0.
- **LFSR:**
  - 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, period 255, never zero.
  - Advances every cycle while `enable`=1 and `game_over`==0.
- **Halt:** if `enable`=0 or any `game_over` bit is set, `step` and `submit` are ignored and outputs hold. `correct` still returns to 0.
- **Cycle order:** a `submit` in the same cycle as a `step` is evaluated against the pre-step state.
- **Submit:**
  - Candidates are active slots with letter == `guess`.
  - Only the lowest-index candidate is cleared: active=0, letter=0, ypos=0, and its `correct` bit pulses.
  - With no match, nothing changes and no pulse is produced.
- **Step, slot advance:** each active slot that was not cleared this cycle advances:
  - if ypos < `FLOOR_Y`, ypos increments;
  - if ypos == `FLOOR_Y`, its `game_over` bit is set and ypos stays at `FLOOR_Y`.
  - Several slots landing on the same step set several bits.
- **Step, spawn counter:**
  - If the counter < `SPAWN_GAP`-1, it increments.
  - Otherwise it tries to spawn into the lowest-index slot that was free at the start of the cycle. A slot freed by a `submit` this cycle is not eligible.
  - Spawn loads letter = current LFSR value and ypos = 0, and sets the slot active. A freshly spawned slot does not advance on that step. The counter returns to 0.
  - If no slot is free, the counter saturates at `SPAWN_GAP`-1 and the spawn retries on each later step.
- **Mid-game reset:** all state returns to reset values asynchronously; there is no partial-clear path.

## Timing
- All outputs are registered; latency is 1 cycle from `step`/`submit` to the updated outputs.
- `correct` is high for exactly 1 cycle, the cycle after `submit`.
- `game_over` is visible the cycle after the landing step and holds until `reset`.
- `step` and `submit` are sampled every cycle, with no handshake. Back-to-back pulses on consecutive cycles are each honoured.
- Spawn cadence: with no blocking, spawns occur on the `SPAWN_GAP`th step, then every `SPAWN_GAP` steps after that.
- A slot spawned at ypos 0 lands on the (`FLOOR_Y`+1)th step after spawn.

## Structure
- **Shared package `flippy_bit_pkg`:**
  - `NUM_SLOTS`=3, `LETTER_W`=8, `YPOS_W`=5, `GRID_W`=40, `GRID_H`=30.
  - LFSR tap mask 8'hB8.
  - Slot struct {active, letter, ypos}.
- **Sub-module `lfsr8`:** ports `CLOCK_50`, `reset`, `advance`, and `value`[7:0]; seed given by parameter.
- Slot update logic is a generate loop over `NUM_SLOTS`.
- A priority encoder finds the lowest free slot and the lowest matching slot.

## Test plan
- **Reset / enable:** assert `reset` mid-game, then enable with no steps → all outputs 0; the LFSR matches a model seeded 8'hA5 after N cycles.
- **First spawn and fall:** 8 steps → `active`=3'b001, ypos1=0, letter1 = model LFSR value. 29 more steps → ypos1=29. One more step → `game_over`=3'b001; further steps and submits produce no change.
- **Correct submit:** slot0 holds letter 8'h5C at ypos 4; `submit` with `guess`=8'h5C → next cycle `correct`=3'b001, then 3'b000 the following cycle; letter1=0 and `active`[0]=0.
- **Duplicates and misses:** slots 0 and 2 both hold 8'h33 → `submit` 8'h33 clears slot0 only. `submit` 8'h34 → no `correct` pulse and no state change.
- **Simultaneous submit and step:** `submit` and `step` in the same cycle while the counter is at 7 and all slots are full → the matched slot is cleared, no spawn occurs, and the counter holds at 7. The next step spawns into the freed slot.
- **Enable low:** deassert `enable` with slots falling → steps and submits are ignored for 20 cycles and the LFSR value is unchanged; after `enable` is reasserted, motion resumes from the held ypos.
